// File: rtl/jtkiwi_pkg.sv
// Shared definitions for the Kiwi shared-RAM arbiter: FSM encoding,
// grant identifiers and the debug status byte layout.
package jtkiwi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ACC  = 3'd1,
    ST_LAT  = 3'd2
  } shram_st_e;

  localparam logic GNT_MAIN  = 1'b0;
  localparam logic GNT_SUB   = 1'b1;
  localparam int   ST_LG_BIT = 3;

  // status byte: {4'd0, last_grant, state[2:0]}
  function automatic logic [7:0] st_pack(input logic lg, input shram_st_e st);
    return {4'd0, lg, st};
  endfunction

endpackage

// File: rtl/jtframe_ram.sv
// Single-port synchronous RAM, one clock read latency, read-before-write.
module jtframe_ram #(
  parameter int AW = 13,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] din,
  input  logic          we,
  output logic [DW-1:0] q
);

  logic [DW-1:0] mem [0:(2**AW)-1];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= din;
    q <= mem[addr];
  end

endmodule

// File: rtl/jtkiwi_shram.sv
// Shared RAM between the main and sub CPUs: a three-state arbiter grants one
// side at a time and holds the other in wait until its access completes.
module jtkiwi_shram
  import jtkiwi_pkg::*;
#(
  parameter int AW = 13,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          m_cs,
  input  logic          m_rnw,
  input  logic [AW-1:0] m_addr,
  input  logic [DW-1:0] m_din,
  output logic [DW-1:0] m_dout,
  output logic          m_wait,
  input  logic          s_cs,
  input  logic          s_rnw,
  input  logic [AW-1:0] s_addr,
  input  logic [DW-1:0] s_din,
  output logic [DW-1:0] s_dout,
  output logic          s_wait,
  output logic [7:0]    st_dout
);

  shram_st_e     state;
  logic          m_served, s_served;
  logic          last_grant, gnt;
  logic          cap_rnw;
  logic [AW-1:0] cap_addr;
  logic [DW-1:0] cap_din;
  logic [DW-1:0] ram_q;
  logic          ram_we;
  logic          m_elig, s_elig, pick;

  assign m_elig  = m_cs & ~m_served;
  assign s_elig  = s_cs & ~s_served;
  assign m_wait  = m_elig;
  assign s_wait  = s_elig;
  // on a collision the side that did not win last time goes first
  assign pick    = (m_elig & s_elig) ? ~last_grant : s_elig;
  assign ram_we  = rstn & (state == ST_ACC) & ~cap_rnw;
  assign st_dout = st_pack(last_grant, state);

  jtframe_ram #(.AW(AW), .DW(DW)) u_ram (
    .clk  (clk),
    .addr (cap_addr),
    .din  (cap_din),
    .we   (ram_we),
    .q    (ram_q)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= ST_IDLE;
      m_served   <= 1'b0;
      s_served   <= 1'b0;
      last_grant <= GNT_SUB;
      gnt        <= GNT_MAIN;
      cap_rnw    <= 1'b1;
      cap_addr   <= '0;
      cap_din    <= '0;
      m_dout     <= '0;
      s_dout     <= '0;
    end else begin
      case (state)
        ST_IDLE: if (m_elig | s_elig) begin
          // only contended grants move last_grant
          if (m_elig & s_elig) last_grant <= pick;
          gnt      <= pick;
          cap_rnw  <= pick ? s_rnw  : m_rnw;
          cap_addr <= pick ? s_addr : m_addr;
          cap_din  <= pick ? s_din  : m_din;
          state    <= ST_ACC;
        end
        ST_ACC: state <= ST_LAT;
        ST_LAT: begin
          if (gnt == GNT_SUB) begin
            if (cap_rnw) s_dout <= ram_q;
            s_served <= 1'b1;
          end else begin
            if (cap_rnw) m_dout <= ram_q;
            m_served <= 1'b1;
          end
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
      // a dropped chip select always re-arms the side
      if (!m_cs) m_served <= 1'b0;
      if (!s_cs) s_served <= 1'b0;
    end
  end

endmodule

// File: tb/tb_jtkiwi_shram.sv
// Self-checking bench for jtkiwi_shram: vector table of single accesses plus
// hand sequences for collisions, held chip select and reset mid-access.
module tb_jtkiwi_shram;

  logic        clk = 1'b0;
  logic        rstn;
  logic        m_cs, m_rnw, s_cs, s_rnw;
  logic [12:0] m_addr, s_addr;
  logic [7:0]  m_din, s_din, m_dout, s_dout, st_dout;
  logic        m_wait, s_wait;

  int n_pass = 0;
  int n_tot  = 0;

  typedef struct {
    logic        side;
    logic        rnw;
    logic [12:0] addr;
    logic [7:0]  din;
    logic [7:0]  exp;
  } vec_t;

  typedef struct {
    logic       side;
    logic [7:0] exp;
  } sb_t;

  vec_t vecs[9];
  sb_t  sbq[$];

  jtkiwi_shram #(.AW(13), .DW(8)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .m_cs    (m_cs),
    .m_rnw   (m_rnw),
    .m_addr  (m_addr),
    .m_din   (m_din),
    .m_dout  (m_dout),
    .m_wait  (m_wait),
    .s_cs    (s_cs),
    .s_rnw   (s_rnw),
    .s_addr  (s_addr),
    .s_din   (s_din),
    .s_dout  (s_dout),
    .s_wait  (s_wait),
    .st_dout (st_dout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic drive(input logic side, input logic rnw, input logic [12:0] addr,
                       input logic [7:0] din);
    if (side) begin s_cs = 1'b1; s_rnw = rnw; s_addr = addr; s_din = din; end
    else      begin m_cs = 1'b1; m_rnw = rnw; m_addr = addr; m_din = din; end
  endtask

  task automatic pop_check(input string name);
    sb_t e;
    if (sbq.size() == 0) begin
      check({name, "_sb_empty"}, 1, 0);
      return;
    end
    e = sbq.pop_front();
    check(name, e.side ? s_dout : m_dout, e.exp);
  endtask

  // one uncontended access; inputs scrambled after grant to prove capture
  task automatic single(input string name, input logic side, input logic rnw,
                        input logic [12:0] addr, input logic [7:0] din,
                        input logic [7:0] exp);
    int n = 0;
    drive(side, rnw, addr, din);
    sbq.push_back('{side, exp});
    do begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        if (side) begin s_addr = ~addr; s_din = ~din; s_rnw = ~rnw; end
        else      begin m_addr = ~addr; m_din = ~din; m_rnw = ~rnw; end
      end
    end while ((side ? s_wait : m_wait) && n < 20);
    check({name, "_lat"}, n, 3);
    check({name, "_other_wait"}, side ? m_wait : s_wait, 0);
    pop_check({name, "_dout"});
    m_cs = 1'b0; s_cs = 1'b0;
    @(negedge clk);
  endtask

  // both sides request on the same clock; reports when each wait fell
  task automatic collide(input string name, input logic m_first,
                         input logic m_rnw_i, input logic [12:0] m_a, input logic [7:0] m_d,
                         input logic [7:0] m_exp,
                         input logic s_rnw_i, input logic [12:0] s_a, input logic [7:0] s_d,
                         input logic [7:0] s_exp);
    int tm = 0, ts = 0;
    drive(1'b0, m_rnw_i, m_a, m_d);
    drive(1'b1, s_rnw_i, s_a, s_d);
    if (m_first) begin sbq.push_back('{1'b0, m_exp}); sbq.push_back('{1'b1, s_exp}); end
    else         begin sbq.push_back('{1'b1, s_exp}); sbq.push_back('{1'b0, m_exp}); end
    for (int i = 1; i <= 20 && (tm == 0 || ts == 0); i++) begin
      @(negedge clk);
      if (!m_wait && tm == 0) tm = i;
      if (!s_wait && ts == 0) ts = i;
    end
    check({name, "_m_lat"}, tm, m_first ? 3 : 6);
    check({name, "_s_lat"}, ts, m_first ? 6 : 3);
    check({name, "_last_grant"}, st_dout[3], m_first ? 0 : 1);
    pop_check({name, "_dout_a"});
    pop_check({name, "_dout_b"});
    m_cs = 1'b0; s_cs = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int acc_cnt;
    int wait_hi;
    vecs[0] = '{1'b0, 1'b0, 13'h0000, 8'h11, 8'h5A};
    vecs[1] = '{1'b1, 1'b0, 13'h1FFF, 8'hEE, 8'h00};
    vecs[2] = '{1'b1, 1'b1, 13'h0000, 8'h00, 8'h11};
    vecs[3] = '{1'b0, 1'b1, 13'h1FFF, 8'h00, 8'hEE};
    vecs[4] = '{1'b0, 1'b0, 13'h1FFE, 8'h77, 8'hEE};
    vecs[5] = '{1'b1, 1'b1, 13'h1FFE, 8'h00, 8'h77};
    vecs[6] = '{1'b1, 1'b0, 13'h0123, 8'hC3, 8'h77};
    vecs[7] = '{1'b0, 1'b1, 13'h0123, 8'h00, 8'hC3};
    vecs[8] = '{1'b0, 1'b0, 13'h0010, 8'h3C, 8'hC3};

    m_cs = 0; m_rnw = 1; m_addr = '0; m_din = '0;
    s_cs = 0; s_rnw = 1; s_addr = '0; s_din = '0;
    rstn = 1'b0;
    @(negedge clk);
    do_reset();

    check("rst_st", st_dout, 8'h08);
    check("rst_m_wait", m_wait, 0);
    check("rst_s_wait", s_wait, 0);
    check("rst_m_dout", m_dout, 0);
    check("rst_s_dout", s_dout, 0);

    single("m_wr_0123", 1'b0, 1'b0, 13'h0123, 8'h5A, 8'h00);
    single("m_rd_0123", 1'b0, 1'b1, 13'h0123, 8'h00, 8'h5A);

    foreach (vecs[i])
      single($sformatf("vec%0d", i), vecs[i].side, vecs[i].rnw, vecs[i].addr,
             vecs[i].din, vecs[i].exp);

    // reset keeps RAM; first collision goes to main and sees old data
    do_reset();
    check("rst2_m_dout", m_dout, 0);
    collide("col1", 1'b1, 1'b1, 13'h0010, 8'h00, 8'h3C, 1'b0, 13'h0010, 8'hA5, 8'h00);
    single("m_rd_0010", 1'b0, 1'b1, 13'h0010, 8'h00, 8'hA5);
    collide("col2", 1'b0, 1'b1, 13'h0123, 8'h00, 8'hC3, 1'b1, 13'h0000, 8'h00, 8'h11);

    // held chip select after service must not trigger another access
    acc_cnt = 0; wait_hi = 0;
    drive(1'b0, 1'b1, 13'h1FFE, 8'h00);
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      if (st_dout[2:0] == 3'd1) acc_cnt++;
      if (i >= 2 && m_wait) wait_hi++;
    end
    check("hold_acc_cnt", acc_cnt, 1);
    check("hold_wait_hi", wait_hi, 0);
    check("hold_idle", st_dout[2:0], 0);
    check("hold_dout", m_dout, 8'h77);
    m_cs = 1'b0;
    @(negedge clk);

    // reset during the ACC of a sub write must suppress the write
    drive(1'b1, 1'b0, 13'h1FFF, 8'h33);
    @(negedge clk);
    check("abort_in_acc", st_dout[2:0], 1);
    rstn = 1'b0; s_cs = 1'b0;
    @(negedge clk);
    check("abort_st", st_dout, 8'h08);
    check("abort_m_dout", m_dout, 0);
    check("abort_s_dout", s_dout, 0);
    check("abort_m_wait", m_wait, 0);
    check("abort_s_wait", s_wait, 0);
    rstn = 1'b1;
    @(negedge clk);
    single("m_rd_1fff", 1'b0, 1'b1, 13'h1FFF, 8'h00, 8'hEE);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
